// File: rtl/riscat_pkg.sv
// Shared types for the riscat execute stage: XLEN, ALU op codes and execute FSM states.
package riscat_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassb = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } exec_state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == AluSll) || (op == AluSrl) || (op == AluSra);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath plus a one-bit shift step used by the serial shifter.
module alu_comb
  import riscat_pkg::*;
(
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  input  alu_op_t         step_op,
  input  logic [XLEN-1:0] step_in,
  output logic [XLEN-1:0] step_out
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      AluAdd:   result = a + b;
      AluSub:   result = a - b;
      AluSll:   result = a << shamt;
      AluSlt:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      AluSltu:  result = {{(XLEN-1){1'b0}}, a < b};
      AluXor:   result = a ^ b;
      AluSrl:   result = a >> shamt;
      AluSra:   result = $unsigned($signed(a) >>> shamt);
      AluOr:    result = a | b;
      AluAnd:   result = a & b;
      AluPassb: result = b;
      default:  result = '0;
    endcase
  end

  always_comb begin
    step_out = step_in;
    case (step_op)
      AluSll:  step_out = {step_in[XLEN-2:0], 1'b0};
      AluSrl:  step_out = {1'b0, step_in[XLEN-1:1]};
      AluSra:  step_out = {step_in[XLEN-1], step_in[XLEN-1:1]};
      default: step_out = step_in;
    endcase
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: accepts one decoded op at a time, runs shifts serially when SERIAL_SHIFT=1,
// and presents each result for exactly one cycle in DONE.
module execute_unit
  import riscat_pkg::*;
#(
  parameter bit SERIAL_SHIFT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  alu_op_t         alu_op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            result_ready,
  output logic [XLEN-1:0] alu_result,
  output logic [4:0]      wr_addr,
  output logic            busy
);

  exec_state_t     state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  alu_op_t         op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      wr_q, wr_d;

  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] comb_result;
  logic [XLEN-1:0] step_result;
  logic            accept;
  logic            go_serial;

  assign operand_b = use_imm ? imm : rs2_val;
  assign op_ready  = (state_q == StIdle) || (state_q == StDone);
  assign busy      = (state_q == StShift);
  assign accept    = op_valid && op_ready && !flush;
  assign go_serial = SERIAL_SHIFT && is_shift(alu_op) && (operand_b[4:0] != 5'd0);

  alu_comb u_alu (
    .op       (alu_op),
    .a        (rs1_val),
    .b        (operand_b),
    .result   (comb_result),
    .step_op  (op_q),
    .step_in  (acc_q),
    .step_out (step_result)
  );

  // res/wr are only loaded on entry to DONE, so they read 0 whenever result_ready is low.
  assign result_ready = (state_q == StDone);
  assign alu_result   = res_q;
  assign wr_addr      = wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_d    = op_q;
    rd_d    = rd_q;
    res_d   = '0;
    wr_d    = '0;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            if (go_serial) begin
              state_d = StShift;
              cnt_d   = operand_b[4:0];
              acc_d   = rs1_val;
              op_d    = alu_op;
              rd_d    = rd_addr;
            end else begin
              state_d = StDone;
              cnt_d   = '0;
              res_d   = comb_result;
              wr_d    = rd_addr;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StShift: begin
          acc_d = step_result;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = StDone;
            res_d   = step_result;
            wr_d    = rd_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_q    <= AluAdd;
      rd_q    <= '0;
      res_q   <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Directed scoreboard bench for execute_unit with SERIAL_SHIFT=1.
module tb_execute_unit;
  import riscat_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  alu_op_t     alu_op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        use_imm;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        result_ready;
  logic [31:0] alu_result;
  logic [4:0]  wr_addr;
  logic        busy;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  execute_unit #(.SERIAL_SHIFT(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .alu_op       (alu_op),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .imm          (imm),
    .use_imm      (use_imm),
    .rd_addr      (rd_addr),
    .flush        (flush),
    .result_ready (result_ready),
    .alu_result   (alu_result),
    .wr_addr      (wr_addr),
    .busy         (busy)
  );

  function automatic logic [31:0] model(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = a;
    case (op)
      AluAdd:   r = a + b;
      AluSub:   r = a + ~b + 32'd1;
      AluSll:   for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], 1'b0};
      AluSrl:   for (int i = 0; i < int'(b[4:0]); i++) r = {1'b0, r[31:1]};
      AluSra:   for (int i = 0; i < int'(b[4:0]); i++) r = {r[31], r[31:1]};
      AluSlt:   r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      AluSltu:  r = {31'd0, a < b};
      AluXor:   r = a ^ b;
      AluOr:    r = a | b;
      AluAnd:   r = a & b;
      AluPassb: r = b;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and score whatever the DUT presents.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (result_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {31'd0, result_ready}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", alu_result, e.res);
        check("wr_addr", {27'd0, wr_addr}, {27'd0, e.wr});
      end
    end else begin
      check("idle_result_zero", alu_result, 32'd0);
      check("idle_wr_zero", {27'd0, wr_addr}, 32'd0);
    end
  endtask

  task automatic send(alu_op_t op, logic [31:0] a, logic [31:0] b, logic [31:0] im,
                      logic ui, logic [4:0] rd, bit push);
    exp_t e;
    alu_op   = op;
    rs1_val  = a;
    rs2_val  = b;
    imm      = im;
    use_imm  = ui;
    rd_addr  = rd;
    op_valid = 1'b1;
    if (push) begin
      e.res = model(op, a, ui ? im : b);
      e.wr  = rd;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_shift(alu_op_t op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    int k;
    k = int'(b[4:0]);
    send(op, a, b, 32'd0, 1'b0, rd, 1'b1);
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      check("shift_busy", {31'd0, busy}, 32'd1);
      check("shift_not_ready", {31'd0, op_ready}, 32'd0);
      tick();
    end
    check("shift_done_pulse", {31'd0, result_ready}, 32'd1);
    check("shift_sb_drained", exp_q.size(), 32'd0);
  endtask

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset    = 1'b1;
    op_valid = 1'b1;
    flush    = 1'b1;
    alu_op   = AluAdd;
    rs1_val  = 32'd0;
    rs2_val  = 32'd0;
    imm      = 32'd0;
    use_imm  = 1'b0;
    rd_addr  = 5'd0;
    tick();
    tick();
    check("reset_rr", {31'd0, result_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    tick();

    // ADD overflow wraps; outputs clear the cycle after.
    send(AluAdd, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd5, 1'b1);
    tick();
    check("add_pulse", {31'd0, result_ready}, 32'd1);
    check("add_value", alu_result, 32'h8000_0000);
    op_valid = 1'b0;
    tick();
    check("add_after_rr", {31'd0, result_ready}, 32'd0);

    // Signed vs unsigned compare on immediate operand.
    send(AluSlt, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 5'd6, 1'b1);
    tick();
    check("slt_value", alu_result, 32'd1);
    send(AluSltu, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 5'd7, 1'b1);
    tick();
    check("sltu_value", alu_result, 32'd0);
    op_valid = 1'b0;
    tick();

    // Single-cycle ops back to back, including zero-amount shifts and an unused code.
    vecs.push_back('{AluSub,   32'd0,          32'd1});
    vecs.push_back('{AluXor,   32'hA5A5_0F0F,  32'hFFFF_0000});
    vecs.push_back('{AluOr,    32'h1200_0034,  32'h0056_7800});
    vecs.push_back('{AluAnd,   32'hDEAD_BEEF,  32'h0F0F_0F0F});
    vecs.push_back('{AluPassb, 32'h1111_1111,  32'hCAFE_F00D});
    vecs.push_back('{AluSll,   32'h8000_0001,  32'h0000_0020});
    vecs.push_back('{AluSra,   32'h8000_0001,  32'hFFFF_FFE0});
    vecs.push_back('{alu_op_t'(4'd13), 32'h1234_5678, 32'h1});
    vecs.push_back('{AluAdd,   32'hFFFF_FFFF,  32'd2});
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, 32'd0, 1'b0, 5'(i + 10), 1'b1);
      tick();
      check("b2b_single_pulse", {31'd0, result_ready}, 32'd1);
    end
    op_valid = 1'b0;
    tick();
    check("single_sb_drained", exp_q.size(), 32'd0);

    // Serial shifts.
    run_shift(AluSra, 32'h8000_0000, 32'h0000_0024, 5'd9);
    check("sra_value", alu_result, 32'hF800_0000);
    run_shift(AluSrl, 32'hF000_0000, 32'h0000_0003, 5'd3);
    run_shift(AluSll, 32'h0000_0001, 32'h0000_001F, 5'd31);
    tick();

    // Three ADDs with op_valid held high.
    for (int i = 0; i < 3; i++) begin
      send(AluAdd, 32'd100 * 32'(i), 32'd7, 32'd0, 1'b0, 5'(20 + i), 1'b1);
      tick();
      check("b2b_add_pulse", {31'd0, result_ready}, 32'd1);
    end
    op_valid = 1'b0;
    tick();

    // Op held upstream while a shift is busy is accepted once DONE is reached.
    send(AluSrl, 32'h0000_00F0, 32'd2, 32'd0, 1'b0, 5'd1, 1'b1);
    tick();
    send(AluXor, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd2, 1'b0);
    tick();
    check("held_busy", {31'd0, busy}, 32'd1);
    tick();
    check("held_srl_pulse", {31'd0, result_ready}, 32'd1);
    send(AluXor, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd2, 1'b1);
    tick();
    check("held_xor_pulse", {31'd0, result_ready}, 32'd1);
    op_valid = 1'b0;
    tick();

    // Flush mid-shift together with a new op: neither produces a result.
    send(AluSll, 32'h0000_0001, 32'd10, 32'd0, 1'b0, 5'd4, 1'b0);
    tick();
    op_valid = 1'b0;
    tick();
    tick();
    send(AluAdd, 32'd1, 32'd1, 32'd0, 1'b0, 5'd8, 1'b0);
    flush = 1'b1;
    tick();
    check("flush_rr", {31'd0, result_ready}, 32'd0);
    check("flush_idle_ready", {31'd0, op_ready}, 32'd1);
    check("flush_idle_busy", {31'd0, busy}, 32'd0);
    flush    = 1'b0;
    op_valid = 1'b0;
    repeat (12) tick();

    // Reset mid-shift aborts the op; an ADD afterwards completes normally.
    run_shift(AluSrl, 32'h1, 32'd0, 5'd0);
    send(AluSra, 32'h8000_0000, 32'd8, 32'd0, 1'b0, 5'd12, 1'b0);
    tick();
    op_valid = 1'b0;
    tick();
    reset    = 1'b1;
    op_valid = 1'b1;
    tick();
    check("rst_mid_rr", {31'd0, result_ready}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ready", {31'd0, op_ready}, 32'd1);
    reset    = 1'b0;
    op_valid = 1'b0;
    repeat (10) tick();
    send(AluAdd, 32'd40, 32'd2, 32'd0, 1'b0, 5'd30, 1'b1);
    tick();
    check("post_rst_add", alu_result, 32'd42);
    op_valid = 1'b0;
    tick();

    check("final_sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The parameter SERIAL_SHIFT SHALL default to 1; at 1, shifts iterate one bit per cycle, and at 0, all ops complete in one cycle.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_valid  input  1  decoded op present this cycle.
REQ-005 op_ready  output  1  unit can accept an op this cycle.
REQ-006 alu_op  input  4  operation code, alu_op_t from the shared package.
REQ-007 rs1_val  input  32  operand A.
REQ-008 rs2_val  input  32  register operand B.
REQ-009 imm  input  32  sign-extended immediate.
REQ-010 use_imm  input  1  1 selects imm as operand B, 0 selects rs2_val.
REQ-011 rd_addr  input  5  destination register.
REQ-012 flush  input  1  discards any in-flight op.
REQ-013 result_ready  output  1  one-cycle pulse marking a valid result for writeback.
REQ-014 alu_result  output  32  result value.
REQ-015 wr_addr  output  5  destination register for the result.
REQ-016 busy  output  1  multi-cycle op in progress.

Function
REQ-017 Ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB (result = operand B); any other code yields result 0 and still completes.
REQ-018 Arithmetic SHALL be modulo 2^32; SLT compares signed, SLTU unsigned; the shift amount is operand B[4:0] only.
REQ-019 Handshake: accept occurs on an edge where op_valid && op_ready && !flush; operands and rd_addr are captured at accept.
REQ-020 FSM states are IDLE, SHIFT and DONE; op_ready = (state==IDLE) || (state==DONE); busy = (state==SHIFT).
REQ-021 A non-shift op, or a shift with amount 0, accepted at edge N SHALL go to DONE, with result_ready=1 for exactly the cycle after edge N.
REQ-022 With SERIAL_SHIFT=1, a shift with amount k>0 accepted at edge N SHALL enter SHIFT with counter=k, shift by one bit and decrement the counter per edge, and reach DONE with result_ready high for the one cycle after edge N+k.
REQ-023 SRA SHALL replicate bit 31 on each step; SRL and SLL SHALL fill with 0.
REQ-024 From DONE, an accept in the same cycle SHALL proceed per REQ-021/022, giving back-to-back results at one per cycle; otherwise DONE goes to IDLE.
REQ-025 When result_ready=0, alu_result and wr_addr SHALL be 0.
REQ-026 rd_addr=0 still produces a result_ready pulse with wr_addr=0; discarding it is the register file's job.
REQ-027 flush SHALL have priority over both op_valid and in-flight work: next state IDLE, no result_ready on the next cycle, counter cleared.
REQ-028 op_valid while op_ready=0 SHALL be ignored; upstream holds the op.

Reset
REQ-029 While reset=1 at an edge: state IDLE, counter 0, result_ready 0, alu_result 0, wr_addr 0, busy 0; op_ready reads 1 after reset.
REQ-030 reset SHALL override flush and op_valid, and abort a SHIFT mid-count with no result emitted.

Structure
REQ-031 alu_op_t (4-bit enum), the FSM state enum and XLEN=32 SHALL live in a shared package, riscat_pkg.
REQ-032 The single-cycle combinational datapath (all ops, plus a 1-bit shift step) SHALL be the sub-module alu_comb; execute_unit holds the FSM, counter and output registers.

Verification
REQ-033 ADD with rs1=0x7FFFFFFF, rs2=1, rd=5, accepted at edge N -> cycle after N: result_ready=1, alu_result=0x80000000, wr_addr=5; the following cycle all outputs are 0.
REQ-034 SLT with rs1=0xFFFFFFFF, imm=1, use_imm=1 -> result 1; SLTU with the same operands -> result 0.
REQ-035 SRA with rs1=0x80000000, rs2=0x24 (amount 4), SERIAL_SHIFT=1 -> busy for 4 cycles, op_ready=0 during them, result 0xF8000000 after edge N+4.
REQ-036 Three ADDs with op_valid held high -> result_ready high for 3 consecutive cycles with the correct results and wr_addr values.
REQ-037 SLL amount 10 accepted, flush asserted 3 cycles later together with a new op_valid -> no result_ready for either op, IDLE on the next cycle.
REQ-038 reset asserted mid-SHIFT -> all outputs 0 after the edge and op_ready=1; a subsequent ADD completes normally.
